// File: rtl/ex_operand_latch.sv
// ID/EX operand latch with EX-stage forwarding muxes and load-use hazard detection.
// Latency: one cycle from decode fields to registered EX entry; operands combinational from it.
// Backpressure: stall holds every register; flush and load-use insert a zeroed bubble.
module ex_operand_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_ctrl,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_use_imm,
  input  logic        id_use_shamt,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        exmem_reg_write,
  input  logic        memwb_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_data,
  input  logic [31:0] memwb_data,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [4:0]  ex_rd,
  output logic        load_use_stall
);

  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic        ex_use_imm;
  logic        ex_use_shamt;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        bubble;

  // A loaded word in EX whose destination feeds the instruction in decode cannot be forwarded in time.
  assign load_use_stall = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                          ((ex_rd == id_rs) || (ex_rd == id_rt));

  // Reset, flush, or an unstalled load-use hazard all zero the entry; stall only holds otherwise.
  assign bubble = !rst_n || flush || (!stall && load_use_stall);

  // Pipeline register: clear on bubble, hold on stall, else capture decode.
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid     <= 1'b0;
      alu_ctrl     <= 4'd0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_imm       <= 32'd0;
      ex_shamt     <= 5'd0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_use_imm   <= 1'b0;
      ex_use_shamt <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      alu_ctrl     <= id_alu_ctrl;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
      ex_shamt     <= id_shamt;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_use_imm   <= id_use_imm;
      ex_use_shamt <= id_use_shamt;
      // Side-effecting controls are gated so an invalid entry can never write state.
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_mem_write <= id_valid && id_mem_write;
    end
  end

  // Forwarding: EX/MEM beats MEM/WB; register 0 always reads its latched value.
  always_comb begin
    fwd_rs = ex_rs_data;
    fwd_rt = ex_rt_data;
    if (ex_rs != 5'd0) begin
      if (exmem_reg_write && (exmem_rd == ex_rs))      fwd_rs = exmem_data;
      else if (memwb_reg_write && (memwb_rd == ex_rs)) fwd_rs = memwb_data;
    end
    if (ex_rt != 5'd0) begin
      if (exmem_reg_write && (exmem_rd == ex_rt))      fwd_rt = exmem_data;
      else if (memwb_reg_write && (memwb_rd == ex_rt)) fwd_rt = memwb_data;
    end
  end

  // Operand selection: shift amount replaces rs, immediate replaces rt; stores always see rt.
  always_comb begin
    alu_a         = ex_use_shamt ? {27'd0, ex_shamt} : fwd_rs;
    alu_b         = ex_use_imm ? ex_imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule

// File: tb/tb_ex_operand_latch.sv
// Randomized and directed bench for ex_operand_latch against an entry-level reference model.
module tb_ex_operand_latch;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic        id_use_imm, id_use_shamt, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        load_use_stall;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  always #5 clk = ~clk;

  ex_operand_latch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctrl(id_alu_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_data(exmem_data), .memwb_data(memwb_data),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .load_use_stall(load_use_stall)
  );

  // Reference: the instruction currently sitting in EX.
  typedef struct packed {
    logic        vld;
    logic [3:0]  op;
    logic [31:0] rs_dat, rt_dat, imm;
    logic [4:0]  sh, rs, rt, rd;
    logic        ui, us, rw, mr, mw;
  } ent_t;

  ent_t m = '0;

  function automatic logic hazard(input ent_t e);
    return e.vld && e.mr && e.rd != 0 && id_valid && (e.rd == id_rs || e.rd == id_rt);
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rn, input logic [31:0] latched);
    if (rn == 0) return latched;
    if (exmem_reg_write && exmem_rd == rn) return exmem_data;
    if (memwb_reg_write && memwb_rd == rn) return memwb_data;
    return latched;
  endfunction

  // Reference entry update, using the inputs present at the edge.
  always @(posedge clk) begin
    ent_t n;
    n = m;
    if (!rst_n || flush)      n = '0;
    else if (stall)           n = m;
    else if (hazard(m))       n = '0;
    else begin
      n = '0;
      n.vld = id_valid;  n.op = id_alu_ctrl;
      n.rs_dat = id_rs_data; n.rt_dat = id_rt_data; n.imm = id_imm;
      n.sh = id_shamt; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
      n.ui = id_use_imm; n.us = id_use_shamt;
      n.rw = id_valid & id_reg_write; n.mr = id_valid & id_mem_read; n.mw = id_valid & id_mem_write;
    end
    m <= n;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m.op});
      cmp("m_alu_a", alu_a, m.us ? {27'd0, m.sh} : fwd(m.rs, m.rs_dat));
      cmp("m_alu_b", alu_b, m.ui ? m.imm : fwd(m.rt, m.rt_dat));
      cmp("m_store", ex_store_data, fwd(m.rt, m.rt_dat));
      cmp("m_valid", {31'd0, ex_valid}, {31'd0, m.vld});
      cmp("m_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, m.rw, m.mr, m.mw});
      cmp("m_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      cmp("m_lus", {31'd0, load_use_stall}, {31'd0, hazard(m)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_alu_ctrl = 4'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
    id_shamt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_use_imm = 1'b0; id_use_shamt = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_data = 32'd0; memwb_data = 32'd0;
  endtask

  task automatic load_add();
    id_valid = 1'b1; id_alu_ctrl = 4'b0000; id_rs = 5'd1; id_rs_data = 32'd5;
    id_rt = 5'd2; id_rt_data = 32'd7; id_rd = 5'd3; id_reg_write = 1'b1;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    step(); step();
    chk_en = 1'b1;
    // Reset state
    cmp("rst_valid", {31'd0, ex_valid}, 32'd0);
    cmp("rst_alu_a", alu_a, 32'd0);
    cmp("rst_lus", {31'd0, load_use_stall}, 32'd0);
    rst_n = 1'b1;

    // ADD operands
    load_add(); step();
    cmp("add_a", alu_a, 32'd5);
    cmp("add_b", alu_b, 32'd7);
    cmp("add_valid", {31'd0, ex_valid}, 32'd1);

    // Double forward with priority, then register 0
    idle_in(); id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h1111; step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAAAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBBBB; #1;
    cmp("fwd_exmem", alu_a, 32'hAAAA);
    exmem_reg_write = 1'b0; #1;
    cmp("fwd_memwb", alu_a, 32'hBBBB);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    id_rs = 5'd0; id_rs_data = 32'h2222; step();
    cmp("fwd_r0", alu_a, 32'h2222);

    // Load-use bubble, then the held decode entry loads
    idle_in(); id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd4; step();
    idle_in(); id_valid = 1'b1; id_rs = 5'd4; id_rd = 5'd5; id_reg_write = 1'b1; id_mem_write = 1'b1; #1;
    cmp("lus_high", {31'd0, load_use_stall}, 32'd1);
    step();
    cmp("lus_bubble", {29'd0, ex_valid, ex_reg_write, ex_mem_write}, 32'd0);
    step();
    cmp("lus_reload", {31'd0, ex_valid}, 32'd1);

    // SLL and LUI operand selection
    idle_in(); id_valid = 1'b1; id_use_shamt = 1'b1; id_shamt = 5'd8;
    id_rt = 5'd2; id_rt_data = 32'h1; id_alu_ctrl = 4'b0110; step();
    cmp("sll_a", alu_a, 32'd8);
    cmp("sll_b", alu_b, 32'd1);
    idle_in(); id_valid = 1'b1; id_use_imm = 1'b1; id_imm = 32'h1234; step();
    cmp("lui_b", alu_b, 32'h1234);

    // Stall holds through changing decode, stall+flush bubbles
    idle_in(); load_add(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = $urandom; id_rt_data = $urandom; id_alu_ctrl = 4'($urandom);
      step();
      cmp("stall_a", alu_a, 32'd5);
      cmp("stall_b", alu_b, 32'd7);
      cmp("stall_valid", {31'd0, ex_valid}, 32'd1);
    end
    flush = 1'b1; step();
    cmp("stflush_valid", {31'd0, ex_valid}, 32'd0);

    // Reset while stalled on a valid entry
    idle_in(); load_add(); step();
    stall = 1'b1; rst_n = 1'b0; step();
    cmp("rst_stall_out", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, alu_ctrl}, 32'd0);
    cmp("rst_stall_ab", alu_a | alu_b | ex_store_data, 32'd0);
    cmp("rst_stall_lus", {31'd0, load_use_stall}, 32'd0);

    // Randomized traffic on a small register space to provoke forwarding and hazards
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_alu_ctrl = 4'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_use_imm = ($urandom_range(0, 3) == 0); id_use_shamt = ($urandom_range(0, 4) == 0);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
      exmem_data = $urandom; memwb_data = $urandom;
      step();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
